pot_adc_responder: RTL and testbench
====================================

POT_ADC_RESPONDER -- requirements
Module: pot_adc_responder

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth for dclk, cs0, cs1 and copi.
REQ-002 Parameter RESET_VALUE, default 10'd512: reset content of every channel register.
REQ-003 clk  input  1  system clock; the only clock.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 dclk  input  1  SPI clock from the pot controller, sampled in the clk domain.
REQ-006 cs0  input  1  active-low select, channels 0-7.
REQ-007 cs1  input  1  active-low select, channels 8-15.
REQ-008 copi  input  1  command data from the controller.
REQ-009 cipo  output  1  response data.
REQ-010 cipo_oe  output  1  high when cipo is driven; the top level tristates cipo otherwise.
REQ-011 wr_en, wr_index[3:0], wr_value[9:0]  input  1/4/10  channel-register write port.
REQ-012 busy  output  1  a transaction is in progress.
REQ-013 xfer_done  output  1  one-cycle pulse after B0 is driven.
REQ-014 err  output  1  one-cycle pulse on a protocol error.

Function
REQ-015 Pass all four SPI inputs through SYNC_STAGES flip-flops; detect dclk rising and falling edges on the synchronized signal.
REQ-016 Support dclk half-periods of at least SYNC_STAGES+3 clk cycles.
REQ-017 cipo shall settle within SYNC_STAGES+2 clk cycles of a dclk falling edge.
REQ-018 Store 16 channel registers of 10 bits; wr_en writes wr_value to wr_index on the next clk edge.
REQ-019 FSM states and transitions:
- IDLE: waits for a copi=1 start bit on a dclk rising edge while exactly one cs is low; then CMD.
- CMD: captures SGL, D2, D1, D0 on four rising edges. On the D0 edge, snapshot the selected channel {cs1_sel, D2, D1, D0} into the shift register; then SAMPLE.
- SAMPLE: on the next rising edge, go to NULL.
- NULL: on the following falling edge, drive cipo=0 with cipo_oe=1; then DATA.
- DATA: drive B9..B0 MSB-first on ten successive falling edges; pulse xfer_done after B0; then DONE.
- DONE: hold cipo=0 until both cs are high; then IDLE.
REQ-020 SGL=0 (differential) shall return 10'd0 in the data bits and pulse err.
REQ-021 Both cs low together shall immediately give IDLE, cipo_oe=0 and an err pulse.
REQ-022 Any cs rising before DONE shall abort to IDLE with cipo_oe=0, no xfer_done and no err.
REQ-023 A write in the same cycle as the snapshot shall not affect the snapshot; later writes shall not affect the transfer in progress.
REQ-024 busy shall be high in every state except IDLE; cipo_oe shall be high only in NULL, DATA and DONE.

Reset
REQ-025 On rst low, asynchronously: state=IDLE, cipo=0, cipo_oe=0, busy=0, xfer_done=0, err=0, synchronizers=1 (idle-high), all channels=RESET_VALUE.

Configuration
REQ-026 Macro POT_ADC_LSB_TAIL_EN.
- Defined: after B0, continue driving B1..B9 LSB-first on nine further falling edges, then DONE; xfer_done pulses after the final B9.
- Undefined: behaviour exactly as REQ-019.

Structure
REQ-027 A shared package pot_adc_pkg shall hold the FSM state enum, the channel count (16), the value width (10) and the command bit count (5).
REQ-028 One sub-module, spi_edge_sync, shall hold the synchronizers and dclk edge detection.

Verification
REQ-029 Write ch3=10'h2A5; cs0 low, command 1,1,0,1,1 -> after null 0, cipo gives 1010100101, then xfer_done pulses.
REQ-030 Write ch11=10'h001; cs1 low, command 1,1,0,1,1 -> data 0000000001.
REQ-031 cs0 low, command 1,0,0,0,0 -> data all zero and one err pulse.
REQ-032 cs0 and cs1 low together mid-CMD -> cipo_oe=0, IDLE and err pulse; a following legal transfer is correct.
REQ-033 Write ch5=10'h3FF in the snapshot cycle, over RESET_VALUE -> transfer returns 10'h200; the next transfer returns 10'h3FF.
REQ-034 Raise cs0 after B4, and separately pulse rst low in DATA -> IDLE, cipo_oe=0, no xfer_done; after rst all channels read 10'h200.

Source files
------------

// File: rtl/pot_adc_pkg.sv
// Shared definitions for the pot ADC responder: FSM states, channel and
// value geometry, and the transfer bit ordering helper.
package pot_adc_pkg;

   localparam int NUM_CH   = 16;
   localparam int VAL_W    = 10;
   localparam int CMD_BITS = 5;   // start, SGL, D2, D1, D0
   localparam int CH_W     = $clog2(NUM_CH);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CMD    = 3'd1,
      ST_SAMPLE = 3'd2,
      ST_NULL   = 3'd3,
      ST_DATA   = 3'd4,
      ST_DONE   = 3'd5
   } pot_state_e;

   // Data bit driven on transfer bit n: B9..B0 MSB-first for n = 0..9,
   // then B1..B9 LSB-first for n = 10..18 (only reached with the tail).
   function automatic logic [3:0] data_bit_index(input logic [4:0] n);
      if (n < 5'(VAL_W))
         return 4'(VAL_W - 1) - n[3:0];
      else
         return 4'(n - 5'(VAL_W - 1));
   endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Synchronizers for the SPI inputs plus dclk edge detection in the clk
// domain. All stages reset high so an idle bus looks deselected. Needs
// SYNC_STAGES >= 2.
module spi_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic dclk,
   input  logic cs0,
   input  logic cs1,
   input  logic copi,
   output logic dclk_s,
   output logic cs0_s,
   output logic cs1_s,
   output logic copi_s,
   output logic dclk_rise,
   output logic dclk_fall
);

   logic [SYNC_STAGES-1:0] dclk_q;
   logic [SYNC_STAGES-1:0] cs0_q;
   logic [SYNC_STAGES-1:0] cs1_q;
   logic [SYNC_STAGES-1:0] copi_q;
   logic                   dclk_d;

   // Shift each input through its synchronizer; keep last dclk for edges.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dclk_q <= '1;
         cs0_q  <= '1;
         cs1_q  <= '1;
         copi_q <= '1;
         dclk_d <= 1'b1;
      end else begin
         dclk_q <= {dclk_q[SYNC_STAGES-2:0], dclk};
         cs0_q  <= {cs0_q[SYNC_STAGES-2:0],  cs0};
         cs1_q  <= {cs1_q[SYNC_STAGES-2:0],  cs1};
         copi_q <= {copi_q[SYNC_STAGES-2:0], copi};
         dclk_d <= dclk_q[SYNC_STAGES-1];
      end
   end

   assign dclk_s    = dclk_q[SYNC_STAGES-1];
   assign cs0_s     = cs0_q[SYNC_STAGES-1];
   assign cs1_s     = cs1_q[SYNC_STAGES-1];
   assign copi_s    = copi_q[SYNC_STAGES-1];
   assign dclk_rise = dclk_s & ~dclk_d;
   assign dclk_fall = ~dclk_s & dclk_d;

endmodule

// File: rtl/pot_adc_responder.sv
// SPI responder emulating a 16-channel 10-bit ADC (two 8-channel banks on
// cs0/cs1). Channel contents come from a local write port.
// Optional feature macro: POT_ADC_LSB_TAIL_EN appends B1..B9 LSB-first
// after B0.
// Handshake note: wr_en is a single-cycle strobe with no back-pressure;
// the SPI side has no handshake beyond cs/dclk framing.
module pot_adc_responder
   import pot_adc_pkg::*;
#(
   parameter int               SYNC_STAGES = 2,
   parameter logic [VAL_W-1:0] RESET_VALUE = 10'd512
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             dclk,
   input  logic             cs0,
   input  logic             cs1,
   input  logic             copi,
   output logic             cipo,
   output logic             cipo_oe,
   input  logic             wr_en,
   input  logic [CH_W-1:0]  wr_index,
   input  logic [VAL_W-1:0] wr_value,
   output logic             busy,
   output logic             xfer_done,
   output logic             err,
   output logic [2:0]       dbg_state
);

`ifdef POT_ADC_LSB_TAIL_EN
   localparam int XFER_BITS = 2 * VAL_W - 1;
`else
   localparam int XFER_BITS = VAL_W;
`endif

   logic dclk_s, cs0_s, cs1_s, copi_s, dclk_rise, dclk_fall;

   spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk       (clk),
      .rst       (rst),
      .dclk      (dclk),
      .cs0       (cs0),
      .cs1       (cs1),
      .copi      (copi),
      .dclk_s    (dclk_s),
      .cs0_s     (cs0_s),
      .cs1_s     (cs1_s),
      .copi_s    (copi_s),
      .dclk_rise (dclk_rise),
      .dclk_fall (dclk_fall)
   );

   pot_state_e       state;
   logic [VAL_W-1:0] ch_q [NUM_CH];
   logic [VAL_W-1:0] data_q;     // snapshot of the addressed channel
   logic [4:0]       bit_cnt;
   logic [2:0]       cmd_q;      // {SGL, D2, D1} once D1 is captured
   logic             cs1_sel;
   logic             sel_cs_s;
   logic             both_low;
   logic             one_low;
   logic [CH_W-1:0]  snap_idx;

   assign sel_cs_s  = cs1_sel ? cs1_s : cs0_s;
   assign both_low  = ~cs0_s & ~cs1_s;
   assign one_low   = cs0_s ^ cs1_s;
   assign snap_idx  = {cs1_sel, cmd_q[1:0], copi_s};
   assign busy      = (state != ST_IDLE);
   assign dbg_state = state;

   // Channel register file; the snapshot reads the pre-write value.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_CH; i++) ch_q[i] <= RESET_VALUE;
      end else if (wr_en) begin
         ch_q[wr_index] <= wr_value;
      end
   end

   // Transaction FSM: bank conflict and deselect take priority over steps.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         cipo      <= 1'b0;
         cipo_oe   <= 1'b0;
         xfer_done <= 1'b0;
         err       <= 1'b0;
         data_q    <= '0;
         bit_cnt   <= '0;
         cmd_q     <= '0;
         cs1_sel   <= 1'b0;
      end else begin
         xfer_done <= 1'b0;
         err       <= 1'b0;
         if (both_low && state != ST_IDLE) begin
            state   <= ST_IDLE;
            cipo    <= 1'b0;
            cipo_oe <= 1'b0;
            err     <= 1'b1;
         end else if (state != ST_IDLE && state != ST_DONE && sel_cs_s) begin
            state   <= ST_IDLE;
            cipo    <= 1'b0;
            cipo_oe <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (dclk_rise && one_low && copi_s) begin
                     state   <= ST_CMD;
                     cs1_sel <= ~cs1_s;
                     bit_cnt <= '0;
                  end
               end
               ST_CMD: begin
                  if (dclk_rise) begin
                     if (bit_cnt == 5'(CMD_BITS - 2)) begin
                        data_q <= cmd_q[2] ? ch_q[snap_idx] : '0;
                        err    <= ~cmd_q[2];
                        state  <= ST_SAMPLE;
                     end else begin
                        cmd_q   <= {cmd_q[1:0], copi_s};
                        bit_cnt <= bit_cnt + 5'd1;
                     end
                  end
               end
               ST_SAMPLE: begin
                  if (dclk_rise) state <= ST_NULL;
               end
               ST_NULL: begin
                  if (dclk_fall) begin
                     cipo    <= 1'b0;
                     cipo_oe <= 1'b1;
                     bit_cnt <= '0;
                     state   <= ST_DATA;
                  end
               end
               ST_DATA: begin
                  if (dclk_fall) begin
                     cipo    <= data_q[data_bit_index(bit_cnt)];
                     bit_cnt <= bit_cnt + 5'd1;
                     if (bit_cnt == 5'(XFER_BITS - 1)) begin
                        xfer_done <= 1'b1;
                        state     <= ST_DONE;
                     end
                  end
               end
               ST_DONE: begin
                  if (dclk_fall) cipo <= 1'b0;
                  if (cs0_s && cs1_s) begin
                     state   <= ST_IDLE;
                     cipo    <= 1'b0;
                     cipo_oe <= 1'b0;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pot_adc_responder.sv
// Directed bench for pot_adc_responder: channel reads on both banks,
// differential command, bank conflict, snapshot-cycle write, aborts.
module tb_pot_adc_responder;

  localparam int HALF = 8;   // dclk half period in clk cycles
`ifdef POT_ADC_LSB_TAIL_EN
  localparam int NBITS = 19;
`else
  localparam int NBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       dclk = 1'b0;
  logic       cs0 = 1'b1;
  logic       cs1 = 1'b1;
  logic       copi = 1'b0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_index = 4'd0;
  logic [9:0] wr_value = 10'd0;
  logic       cipo, cipo_oe, busy, xfer_done, err;
  logic [2:0] dbg_state;

  int tests_run = 0;
  int tests_failed = 0;
  int xfer_cnt = 0;
  int err_cnt = 0;

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, tests_run=%0d", tests_run);
    $fatal(1, "watchdog");
  end

  pot_adc_responder dut (
    .clk       (clk),
    .rst       (rst),
    .dclk      (dclk),
    .cs0       (cs0),
    .cs1       (cs1),
    .copi      (copi),
    .cipo      (cipo),
    .cipo_oe   (cipo_oe),
    .wr_en     (wr_en),
    .wr_index  (wr_index),
    .wr_value  (wr_value),
    .busy      (busy),
    .xfer_done (xfer_done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // pulse counters
  always @(negedge clk) begin
    if (xfer_done === 1'b1) xfer_cnt++;
    if (err === 1'b1) err_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic write_ch(input logic [3:0] idx, input logic [9:0] val);
    @(negedge clk);
    wr_en = 1'b1; wr_index = idx; wr_value = val;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // One dclk period; s is cipo sampled late in the low phase after the fall.
  // With wr_rise set, a write lands on the clk edge that acts on this rise.
  task automatic pulse(input logic v, input logic wr_rise, input logic [3:0] widx,
                       input logic [9:0] wval, output logic s);
    copi = v;
    @(negedge clk);
    dclk = 1'b1;
    if (wr_rise) begin
      @(negedge clk);
      @(negedge clk);
      wr_en = 1'b1; wr_index = widx; wr_value = wval;
      @(negedge clk);
      wr_en = 1'b0;
      repeat (HALF - 3) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
    dclk = 1'b0;
    repeat (HALF - 1) @(negedge clk);
    s = cipo;
  endtask

  // Select, start + command bits, sample and null periods.
  task automatic start_cmd(input logic use_cs1, input logic sgl, input logic [2:0] chan,
                           input logic snap_wr, input logic [3:0] widx, input logic [9:0] wval,
                           output logic null_bit, output logic oe_null);
    logic s;
    if (use_cs1) cs1 = 1'b0; else cs0 = 1'b0;
    repeat (HALF) @(negedge clk);
    pulse(1'b1, 1'b0, 4'd0, 10'd0, s);
    pulse(sgl, 1'b0, 4'd0, 10'd0, s);
    pulse(chan[2], 1'b0, 4'd0, 10'd0, s);
    pulse(chan[1], 1'b0, 4'd0, 10'd0, s);
    pulse(chan[0], snap_wr, widx, wval, s);
    pulse(1'b0, 1'b0, 4'd0, 10'd0, s);
    null_bit = s;
    oe_null = cipo_oe;
  endtask

  task automatic run_xfer(input logic use_cs1, input logic sgl, input logic [2:0] chan,
                          input logic snap_wr, input logic [3:0] widx, input logic [9:0] wval,
                          output logic [9:0] data, output logic [8:0] tail,
                          output logic null_bit, output logic oe_null);
    logic s;
    data = '0;
    tail = '0;
    start_cmd(use_cs1, sgl, chan, snap_wr, widx, wval, null_bit, oe_null);
    for (int i = 0; i < NBITS; i++) begin
      pulse(1'b0, 1'b0, 4'd0, 10'd0, s);
      if (i < 10) data[9 - i] = s;
      else tail[i - 10] = s;
    end
    repeat (HALF) @(negedge clk);
    cs0 = 1'b1;
    cs1 = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (dbg_state !== 3'd0) begin tests_failed++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    tests_run++;
    if ({cipo, cipo_oe, busy, xfer_done, err} !== 5'b0) begin
      tests_failed++; $display("FAIL reset_outputs: got %b want 00000", {cipo, cipo_oe, busy, xfer_done, err});
    end
    rst = 1'b1;
    repeat (4) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_read(input string name, input logic use_cs1, input logic [3:0] ch,
                           input logic [9:0] val);
    logic [9:0] d; logic [8:0] t; logic nb, oe;
    int x0, e0;
    write_ch(ch, val);
    x0 = xfer_cnt; e0 = err_cnt;
    run_xfer(use_cs1, 1'b1, ch[2:0], 1'b0, 4'd0, 10'd0, d, t, nb, oe);
    tests_run++;
    if (nb !== 1'b0 || oe !== 1'b1) begin
      tests_failed++; $display("FAIL %s_null: got null=%b oe=%b want null=0 oe=1", name, nb, oe);
    end
    tests_run++;
    if (d !== val) begin tests_failed++; $display("FAIL %s_data: got %b want %b", name, d, val); end
`ifdef POT_ADC_LSB_TAIL_EN
    tests_run++;
    if (t !== val[9:1]) begin tests_failed++; $display("FAIL %s_tail: got %b want %b", name, t, val[9:1]); end
`endif
    tests_run++;
    if (xfer_cnt - x0 !== 1 || err_cnt - e0 !== 0) begin
      tests_failed++; $display("FAIL %s_pulses: got done=%0d err=%0d want done=1 err=0", name, xfer_cnt - x0, err_cnt - e0);
    end
    tests_run++;
    if (dbg_state !== 3'd0 || cipo_oe !== 1'b0) begin
      tests_failed++; $display("FAIL %s_release: got state=%0d oe=%b want 0/0", name, dbg_state, cipo_oe);
    end
  endtask

  task automatic test_differential;
    logic [9:0] d; logic [8:0] t; logic nb, oe;
    int x0, e0;
    x0 = xfer_cnt; e0 = err_cnt;
    run_xfer(1'b0, 1'b0, 3'd0, 1'b0, 4'd0, 10'd0, d, t, nb, oe);
    tests_run++;
    if (d !== 10'd0) begin tests_failed++; $display("FAIL diff_data: got %b want 0000000000", d); end
    tests_run++;
    if (err_cnt - e0 !== 1) begin tests_failed++; $display("FAIL diff_err: got %0d pulses want 1", err_cnt - e0); end
    tests_run++;
    if (xfer_cnt - x0 !== 1) begin tests_failed++; $display("FAIL diff_done: got %0d pulses want 1", xfer_cnt - x0); end
  endtask

  task automatic test_both_cs;
    logic s; logic [9:0] d; logic [8:0] t; logic nb, oe;
    int e0;
    e0 = err_cnt;
    cs0 = 1'b0;
    repeat (HALF) @(negedge clk);
    pulse(1'b1, 1'b0, 4'd0, 10'd0, s);
    pulse(1'b1, 1'b0, 4'd0, 10'd0, s);
    pulse(1'b0, 1'b0, 4'd0, 10'd0, s);
    cs1 = 1'b0;
    repeat (HALF) @(negedge clk);
    tests_run++;
    if (dbg_state !== 3'd0 || cipo_oe !== 1'b0 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL both_cs_idle: got state=%0d oe=%b busy=%b want 0/0/0", dbg_state, cipo_oe, busy);
    end
    tests_run++;
    if (err_cnt - e0 !== 1) begin tests_failed++; $display("FAIL both_cs_err: got %0d pulses want 1", err_cnt - e0); end
    cs0 = 1'b1; cs1 = 1'b1;
    repeat (2 * HALF) @(negedge clk);
    run_xfer(1'b0, 1'b1, 3'd3, 1'b0, 4'd0, 10'd0, d, t, nb, oe);
    tests_run++;
    if (d !== 10'h2A5) begin tests_failed++; $display("FAIL both_cs_recover: got %h want 2a5", d); end
  endtask

  task automatic test_snapshot_write;
    logic [9:0] d; logic [8:0] t; logic nb, oe;
    run_xfer(1'b0, 1'b1, 3'd5, 1'b1, 4'd5, 10'h3FF, d, t, nb, oe);
    tests_run++;
    if (d !== 10'h200) begin tests_failed++; $display("FAIL snap_same_cycle: got %h want 200", d); end
    run_xfer(1'b0, 1'b1, 3'd5, 1'b0, 4'd0, 10'd0, d, t, nb, oe);
    tests_run++;
    if (d !== 10'h3FF) begin tests_failed++; $display("FAIL snap_next: got %h want 3ff", d); end
  endtask

  task automatic test_abort_cs;
    logic s; logic nb, oe; logic [5:0] hi;
    int x0, e0;
    x0 = xfer_cnt; e0 = err_cnt;
    start_cmd(1'b0, 1'b1, 3'd3, 1'b0, 4'd0, 10'd0, nb, oe);
    for (int i = 0; i < 6; i++) begin
      pulse(1'b0, 1'b0, 4'd0, 10'd0, s);
      hi[5 - i] = s;
    end
    tests_run++;
    if (busy !== 1'b1 || dbg_state !== 3'd4) begin
      tests_failed++; $display("FAIL abort_in_data: got busy=%b state=%0d want 1/4", busy, dbg_state);
    end
    tests_run++;
    if (hi !== 6'b101010) begin tests_failed++; $display("FAIL abort_b9_b4: got %b want 101010", hi); end
    cs0 = 1'b1;
    repeat (HALF) @(negedge clk);
    tests_run++;
    if (dbg_state !== 3'd0 || cipo_oe !== 1'b0) begin
      tests_failed++; $display("FAIL abort_idle: got state=%0d oe=%b want 0/0", dbg_state, cipo_oe);
    end
    tests_run++;
    if (xfer_cnt - x0 !== 0 || err_cnt - e0 !== 0) begin
      tests_failed++; $display("FAIL abort_pulses: got done=%0d err=%0d want 0/0", xfer_cnt - x0, err_cnt - e0);
    end
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic s; logic nb, oe; logic [9:0] d; logic [8:0] t; logic [3:0] ch;
    int x0;
    x0 = xfer_cnt;
    start_cmd(1'b0, 1'b1, 3'd3, 1'b0, 4'd0, 10'd0, nb, oe);
    for (int i = 0; i < 3; i++) pulse(1'b0, 1'b0, 4'd0, 10'd0, s);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (dbg_state !== 3'd0 || cipo_oe !== 1'b0 || busy !== 1'b0 || cipo !== 1'b0) begin
      tests_failed++; $display("FAIL rst_mid_idle: got state=%0d oe=%b busy=%b cipo=%b want 0/0/0/0", dbg_state, cipo_oe, busy, cipo);
    end
    rst = 1'b1;
    cs0 = 1'b1;
    repeat (2 * HALF) @(negedge clk);
    tests_run++;
    if (xfer_cnt - x0 !== 0) begin tests_failed++; $display("FAIL rst_mid_done: got %0d pulses want 0", xfer_cnt - x0); end
    for (int i = 0; i < 16; i++) begin
      ch = i[3:0];
      run_xfer(ch[3], 1'b1, ch[2:0], 1'b0, 4'd0, 10'd0, d, t, nb, oe);
      tests_run++;
      if (d !== 10'h200) begin tests_failed++; $display("FAIL rst_ch%0d: got %h want 200", i, d); end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset;
    test_read("ch3", 1'b0, 4'd3, 10'h2A5);
    test_read("ch11", 1'b1, 4'd11, 10'h001);
    test_differential;
    test_both_cs;
    test_snapshot_write;
    test_abort_cs;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
